// File: rtl/ptt_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ptt_seq_pkg
//  Description : Shared definitions for the PTT changeover sequencer:
//                FSM state encoding, default timing constants and a small
//                width helper used to size internal counters.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ptt_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_KEYUP   = 3'd1,
        ST_TX      = 3'd2,
        ST_KEYDN   = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Defaults for a 48 MHz system clock.
    localparam int C_DEF_PRESCALE  = 1024;
    localparam int C_DEF_N_STEP    = 3;
    localparam int C_DEF_STEP_DLY  = 9375;
    localparam int C_DEF_TMR_W     = 16;
    localparam int C_DEF_DEB_TICKS = 47;
    localparam int C_DEF_TOT_TICKS = 0;
    localparam int C_DEF_TOT_W     = 28;

    // Bits needed to hold 0..count-1; never less than one bit.
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptt_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ptt_tick_gen
//  Description : Free-running prescaler producing a one-clock timing tick
//                every PRESCALE clocks. The first tick appears PRESCALE
//                clocks after reset is released.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                tick - one-clock tick pulse
//  Revision    : 1.0 - initial release
// ============================================================================
import ptt_seq_pkg::*;

module ptt_tick_gen #(
    parameter int PRESCALE = C_DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CNT_W  = width_of(PRESCALE);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded straight from the counter register, so it is glitch-free and
    // lasts exactly one clock per prescale period.
    assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/ptt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ptt_sequencer
//  Description : TX/RX changeover sequencer. N_STEP control lines assert in
//                ascending order on key-up and release in descending order
//                on key-down, followed/preceded by the TX enable. Includes
//                PTT synchroniser and debounce, abort mid-sequence, transmit
//                time-out with lockout, and immediate fault shutdown.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                ptt_i   - asynchronous PTT request
//                fault_i - synchronous fault request (level)
//                seq_o   - sequenced control lines (bit 0 first on, last off)
//                tx_o    - transmit enable, high only in TX
//                busy_o  - high whenever the FSM is not idle
//                tot_o   - time-out / fault lockout indication
//                state_o - current FSM state
//  Revision    : 1.0 - initial release
// ============================================================================
import ptt_seq_pkg::*;

module ptt_sequencer #(
    parameter int PRESCALE  = C_DEF_PRESCALE,
    parameter int N_STEP    = C_DEF_N_STEP,
    parameter int STEP_DLY  = C_DEF_STEP_DLY,
    parameter int TMR_W     = C_DEF_TMR_W,
    parameter int DEB_TICKS = C_DEF_DEB_TICKS,
    parameter int TOT_TICKS = C_DEF_TOT_TICKS,
    parameter int TOT_W     = C_DEF_TOT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ptt_i,
    input  logic               fault_i,
    output logic [N_STEP-1:0]  seq_o,
    output logic               tx_o,
    output logic               busy_o,
    output logic               tot_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int K_W   = width_of(N_STEP);
    localparam int DEB_W = width_of(DEB_TICKS);

    localparam logic [K_W-1:0]   C_K_LAST      = K_W'(N_STEP - 1);
    localparam logic [TMR_W-1:0] C_STEP_RELOAD = TMR_W'(STEP_DLY - 1);
    localparam logic [DEB_W-1:0] C_DEB_LAST    = DEB_W'(DEB_TICKS - 1);
    localparam logic [TOT_W-1:0] C_TOT_LIMIT   = TOT_W'(TOT_TICKS);
    localparam logic             C_TOT_ENABLE  = (TOT_TICKS != 0);

    // ------------------------------------------------------------------
    // Timing tick
    // ------------------------------------------------------------------
    logic w_tick;

    ptt_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic             r_sync1;
    logic             r_sync2;
    logic             r_ptt_db;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             w_db_nxt;

    // The FSM acts on the value the debouncer is about to accept, so a
    // change of PTT is acted on in the very tick that accepts it.
    assign w_db_nxt = (w_tick && (r_sync2 != r_ptt_db) && (r_deb_cnt == C_DEB_LAST))
                      ? r_sync2 : r_ptt_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_ptt_db  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= ptt_i;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_ptt_db <= w_db_nxt;
                if ((r_sync2 == r_ptt_db) || (r_deb_cnt == C_DEB_LAST)) begin
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_busy;
    logic [N_STEP-1:0] r_seq;
    logic              r_tx;
    logic              r_tot;
    logic [K_W-1:0]    r_k;
    logic [TMR_W-1:0]  r_timer;
    logic [TOT_W-1:0]  r_tot_cnt;

    logic [N_STEP-1:0] w_bit_k;
    logic [N_STEP-1:0] w_bit_next;
    logic [TOT_W-1:0]  w_tot_inc;
    logic              w_timeout;

    assign w_bit_k    = N_STEP'(1) << r_k;
    // Only used while r_k < N_STEP-1, so r_k+1 always fits in K_W bits.
    assign w_bit_next = N_STEP'(1) << (r_k + K_W'(1));
    assign w_tot_inc  = (&r_tot_cnt) ? r_tot_cnt : r_tot_cnt + 1'b1;
    assign w_timeout  = C_TOT_ENABLE && (w_tot_inc == C_TOT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_seq     <= '0;
            r_tx      <= 1'b0;
            r_tot     <= 1'b0;
            r_k       <= '0;
            r_timer   <= '0;
            r_tot_cnt <= '0;
        end else if (fault_i) begin
            // Hard shutdown: no orderly release of the lines.
            r_state <= ST_LOCKOUT;
            r_busy  <= 1'b1;
            r_seq   <= '0;
            r_tx    <= 1'b0;
            r_tot   <= 1'b1;
        end else if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_db_nxt) begin
                        r_seq   <= N_STEP'(1);
                        r_k     <= '0;
                        r_timer <= C_STEP_RELOAD;
                        r_state <= ST_KEYUP;
                        r_busy  <= 1'b1;
                    end
                end

                ST_KEYUP: begin
                    if (!w_db_nxt) begin
                        // Abort: release from the highest line already on.
                        r_timer <= C_STEP_RELOAD;
                        r_state <= ST_KEYDN;
                    end else if (r_timer == '0) begin
                        if (r_k != C_K_LAST) begin
                            r_k     <= r_k + K_W'(1);
                            r_seq   <= r_seq | w_bit_next;
                            r_timer <= C_STEP_RELOAD;
                        end else begin
                            r_tx      <= 1'b1;
                            r_tot_cnt <= '0;
                            r_state   <= ST_TX;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                ST_TX: begin
                    r_tot_cnt <= w_tot_inc;
                    if (!w_db_nxt || w_timeout) begin
                        r_tx    <= 1'b0;
                        r_k     <= C_K_LAST;
                        r_timer <= C_STEP_RELOAD;
                        r_state <= ST_KEYDN;
                        // An operator release on the same tick is a normal
                        // key-down, not a time-out.
                        if (w_db_nxt) begin
                            r_tot <= 1'b1;
                        end
                    end
                end

                ST_KEYDN: begin
                    if (r_timer == '0) begin
                        r_seq <= r_seq & ~w_bit_k;
                        if (r_k == '0) begin
                            if (r_tot) begin
                                r_state <= ST_LOCKOUT;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_k     <= r_k - K_W'(1);
                            r_timer <= C_STEP_RELOAD;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    r_seq <= '0;
                    r_tx  <= 1'b0;
                    // Re-arm only once the operator has dropped PTT.
                    if (!w_db_nxt) begin
                        r_tot   <= 1'b0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_seq   <= '0;
                    r_tx    <= 1'b0;
                    r_tot   <= 1'b0;
                end
            endcase
        end
    end

    assign seq_o   = r_seq;
    assign tx_o    = r_tx;
    assign busy_o  = r_busy;
    assign tot_o   = r_tot;
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ptt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ptt_sequencer
//  Description : Self-checking bench for ptt_sequencer. A reference model
//                working in absolute tick numbers predicts every change of
//                the output vector and queues it; a monitor pops and compares
//                each time the DUT output vector changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ptt_sequencer;

    localparam int PRESCALE  = 4;
    localparam int N_STEP    = 3;
    localparam int STEP_DLY  = 3;
    localparam int TMR_W     = 16;
    localparam int DEB_TICKS = 2;
    localparam int TOT_TICKS = 20;
    localparam int TOT_W     = 28;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_TX   = 2;
    localparam int M_DN   = 3;
    localparam int M_LOCK = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ptt_i = 1'b0;
    logic              fault_i = 1'b0;
    logic [N_STEP-1:0] seq_o;
    logic              tx_o;
    logic              busy_o;
    logic              tot_o;
    logic [2:0]        state_o;

    int n_checks = 0;
    int n_pass   = 0;

    ptt_sequencer #(
        .PRESCALE  (PRESCALE),
        .N_STEP    (N_STEP),
        .STEP_DLY  (STEP_DLY),
        .TMR_W     (TMR_W),
        .DEB_TICKS (DEB_TICKS),
        .TOT_TICKS (TOT_TICKS),
        .TOT_W     (TOT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ptt_i   (ptt_i),
        .fault_i (fault_i),
        .seq_o   (seq_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .tot_o   (tot_o),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model (absolute tick times, count of lines switched on)
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic [8:0] vec;
    } exp_t;

    exp_t sb[$];

    int         m_cyc    = 0;
    int         m_clks   = 0;
    int         m_tno    = 0;
    logic       m_s1     = 1'b0;
    logic       m_s2     = 1'b0;
    logic       m_db     = 1'b0;
    int         m_streak = 0;
    int         m_mode   = M_IDLE;
    int         m_lines  = 0;
    int         m_evt    = 0;
    int         m_txst   = 0;
    logic       m_tx     = 1'b0;
    logic       m_tot    = 1'b0;
    logic [8:0] m_prev   = '0;

    always @(posedge clk) begin
        logic       tick;
        logic       db_new;
        logic [2:0] seqv;
        logic [8:0] v;
        m_cyc++;
        if (rst) begin
            m_clks = 0; m_tno = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_streak = 0;
            m_mode = M_IDLE; m_lines = 0; m_tx = 0; m_tot = 0;
        end else begin
            m_clks++;
            tick   = (m_clks % PRESCALE) == 0;
            db_new = m_db;
            if (tick) begin
                m_tno++;
                if (m_s2 != m_db) begin
                    m_streak++;
                    if (m_streak == DEB_TICKS) begin
                        db_new   = m_s2;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            if (fault_i) begin
                m_mode = M_LOCK; m_lines = 0; m_tx = 0; m_tot = 1;
            end else if (tick) begin
                case (m_mode)
                    M_IDLE: if (db_new) begin
                        m_mode = M_UP; m_lines = 1; m_evt = m_tno + STEP_DLY;
                    end
                    M_UP: if (!db_new) begin
                        m_mode = M_DN; m_evt = m_tno + STEP_DLY;
                    end else if (m_tno == m_evt) begin
                        if (m_lines < N_STEP) begin
                            m_lines++; m_evt = m_tno + STEP_DLY;
                        end else begin
                            m_mode = M_TX; m_tx = 1; m_txst = m_tno;
                        end
                    end
                    M_TX: if (!db_new || (m_tno - m_txst == TOT_TICKS)) begin
                        if (db_new) m_tot = 1;
                        m_tx = 0; m_mode = M_DN; m_evt = m_tno + STEP_DLY;
                    end
                    M_DN: if (m_tno == m_evt) begin
                        m_lines--;
                        if (m_lines == 0) m_mode = m_tot ? M_LOCK : M_IDLE;
                        else m_evt = m_tno + STEP_DLY;
                    end
                    default: if (!db_new) begin
                        m_mode = M_IDLE; m_tot = 0;
                    end
                endcase
            end
            m_s2 = m_s1;
            m_s1 = ptt_i;
            m_db = db_new;
        end
        seqv = 3'((1 << m_lines) - 1);
        v = {3'(m_mode), (m_mode != M_IDLE), m_tot, m_tx, seqv};
        if (v != m_prev) begin
            sb.push_back('{cyc: m_cyc, vec: v});
            m_prev = v;
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit         mon_en   = 1'b0;
    logic [8:0] dut_prev = '0;

    always @(negedge clk) begin
        logic [8:0] v;
        exp_t       e;
        if (mon_en) begin
            v = {state_o, busy_o, tot_o, tx_o, seq_o};
            if (v !== dut_prev) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d got=%b expected no change", m_cyc, v);
                end else begin
                    e = sb.pop_front();
                    if (e.vec === v && e.cyc == m_cyc)
                        n_pass++;
                    else
                        $display("FAIL output_change got=%b@%0d expected=%b@%0d (state,busy,tot,tx,seq)",
                                 v, m_cyc, e.vec, e.cyc);
                end
                dut_prev = v;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_seq(input logic [2:0] val, input int limit, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (seq_o === val) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL %s seq_o=%b required=%b within %0d clks", name, seq_o, val, limit);
    endtask

    task automatic wait_tx(input int limit, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_o === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL %s tx_o=%b required=1 within %0d clks", name, tx_o, limit);
    endtask

    initial begin
        clks(3);
        rst = 1'b0;
        mon_en = 1'b1;
        n_checks++;
        if ({state_o, busy_o, tot_o, tx_o, seq_o} === 9'b0) n_pass++;
        else $display("FAIL reset_state got=%b required=%b",
                      {state_o, busy_o, tot_o, tx_o, seq_o}, 9'b0);

        // Normal key-up then key-down
        ptt_i = 1'b1;
        wait_tx(200, "keyup_tx");
        clks(30);
        ptt_i = 1'b0;
        clks(100);

        // Abort at 011, then a one-tick glitch in IDLE
        ptt_i = 1'b1;
        wait_seq(3'b011, 200, "abort_reach_011");
        ptt_i = 1'b0;
        clks(100);
        ptt_i = 1'b1;
        clks(4);
        ptt_i = 1'b0;
        clks(40);

        // Time-out into lockout, held, then released
        ptt_i = 1'b1;
        clks(300);
        ptt_i = 1'b0;
        clks(60);

        // Fault during TX
        ptt_i = 1'b1;
        wait_tx(200, "fault_reach_tx");
        clks(7);
        fault_i = 1'b1;
        clks(1);
        fault_i = 1'b0;
        clks(40);
        ptt_i = 1'b0;
        clks(40);

        // Reset mid key-up, PTT held through it
        ptt_i = 1'b1;
        wait_seq(3'b011, 200, "reset_reach_011");
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        clks(100);
        ptt_i = 1'b0;
        clks(120);

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rst = 1'b1;
                clks(1);
                rst = 1'b0;
            end else if (r < 12) begin
                fault_i = 1'b1;
                clks($urandom_range(1, 3));
                fault_i = 1'b0;
            end else begin
                ptt_i = ~ptt_i;
            end
            clks($urandom_range(1, 140));
        end

        // Drain
        ptt_i   = 1'b0;
        fault_i = 1'b0;
        clks(400);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        n_checks++;
        if (state_o === 3'd0 && busy_o === 1'b0) n_pass++;
        else $display("FAIL final_idle state_o=%0d busy_o=%b required state 0 busy 0", state_o, busy_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ptt_sequencer.md
Name: ptt_sequencer

Overview:
Parametrised TX/RX changeover sequencer for the transmit chain. It is the generalised successor of the single-relay PTT sequencer. It drives N_STEP ordered control lines (e.g. antenna relay, LNA mute, PA bias) plus a final TX enable. Lines assert in ascending order on key-up and release in descending order on key-down. It adds input debounce, abort mid-sequence, a transmit time-out timer with lockout, and an immediate fault shutdown. It sits between the host PTT request and the RF front-end control pins.

Parameters:
PRESCALE, 1024, clk cycles per timing tick (48 MHz / 1024 = 21.33 us tick)
N_STEP, 3, number of sequenced lines, 1..8
STEP_DLY, 9375, ticks between successive steps (200 ms at default); must be >= 1
TMR_W, 16, width of step timer; STEP_DLY < 2**TMR_W
DEB_TICKS, 47, ticks ptt must be stable before accepted (~1 ms); must be >= 1
TOT_TICKS, 0, transmit time-out in ticks; 0 disables time-out
TOT_W, 28, width of time-out counter

Ports:
clk  in  1  system clock, 48 MHz
rst  in  1  synchronous reset, active-high
ptt_i  in  1  asynchronous PTT request
fault_i  in  1  synchronous fault request (e.g. PA over-temperature), level
seq_o  out  N_STEP  sequenced control lines; bit 0 first on, last off
tx_o  out  1  transmit enable; high only in TX state
busy_o  out  1  high in any state other than IDLE
tot_o  out  1  time-out / fault lockout indication
state_o  out  3  current FSM state (encoding in package)

Behaviour:
- Reset (synchronous, active-high): seq_o=0, tx_o=0, busy_o=0, tot_o=0, state=IDLE. Prescaler, step timer, step index k, debounce counter, TOT counter and both sync flops are cleared.
- Tick: one-clk pulse every PRESCALE clks; first tick occurs PRESCALE clks after reset release. The FSM, debounce and timers advance only on tick cycles. fault_i is evaluated every clk.
- ptt_i passes a 2-flop synchroniser. The debounced signal ptt_db changes only after DEB_TICKS consecutive ticks of a sampled value differing from ptt_db; any agreeing sample reloads the counter.
- IDLE: all outputs 0. On ptt_db=1: seq_o[0]<=1, k<=0, timer<=STEP_DLY-1, go to KEYUP.
- KEYUP: if ptt_db=0 (abort), go to KEYDN with k unchanged and timer reloaded. Else if timer=0 and k<N_STEP-1: k<=k+1, set seq_o[k+1], reload timer. Else if timer=0 and k=N_STEP-1: tx_o<=1, clear TOT counter, go to TX. Else timer--.
- Net key-up latency: seq_o[i] rises i*STEP_DLY ticks after seq_o[0]; tx_o rises N_STEP*STEP_DLY ticks after seq_o[0].
- TX: TOT counter increments per tick, saturating. If ptt_db=0: tx_o<=0, k<=N_STEP-1, reload timer, go to KEYDN. If TOT_TICKS!=0 and the counter reaches TOT_TICKS: same actions, and tot_o<=1. Release takes priority when both occur on the same tick (tot_o stays 0).
- KEYDN: ptt_db is ignored; no re-key until IDLE. On timer=0: clear seq_o[k]. If k=0, go to LOCKOUT when tot_o=1, else to IDLE. Otherwise k--, reload. Else timer--. seq_o[k] falls STEP_DLY ticks after entry, each lower line STEP_DLY later.
- LOCKOUT: all seq_o/tx_o 0, tot_o=1. Exit to IDLE (tot_o<=0) on a tick with ptt_db=0 and fault_i=0. Operator must drop PTT to re-arm.
- fault_i=1 in any state, any clk: next edge seq_o=0, tx_o=0, tot_o=1, state=LOCKOUT. No sequencing, fault wins over all other events.
- rst asserted mid-sequence: all outputs drop on the next edge; no orderly key-down.
- busy_o = (state!=IDLE), registered together with the state.

Decomposition:
- Package ptt_seq_pkg holds the state encoding: IDLE=0, KEYUP=1, TX=2, KEYDN=3, LOCKOUT=4. It also holds the default timing constants and a STATE_W=3 constant.
- Sub-module ptt_tick_gen (PRESCALE counter emitting the tick pulse, synchronous reset).
- Synchroniser, debounce, FSM and counters stay in ptt_sequencer.

Test Plan:
Bench parameters for all scenarios: PRESCALE=4, N_STEP=3, STEP_DLY=3, DEB_TICKS=2, TOT_TICKS=20.
1. Normal key-up: ptt_i high and held -> seq_o 001, 011, 111 at 12-clk spacing; tx_o rises 12 clks after seq_o=111; state_o=2.
2. Key-down: from TX drop ptt_i -> tx_o falls on the debounce-accept tick. seq_o goes 011, 001, 000 at 12-clk spacing; state_o returns to 0; busy_o=0.
3. Abort: release ptt_i when seq_o=011 -> tx_o never rises; seq_o 001 then 000 at 12-clk spacing. A 1-tick ptt_i glitch during IDLE produces no change.
4. Time-out: hold ptt_i -> 20 ticks after tx_o rises, tx_o=0 and tot_o=1; reverse sequence runs; state LOCKOUT. It stays there while ptt_i=1 and returns to IDLE (tot_o=0) after release plus debounce.
5. Fault: pulse fault_i one clk during TX -> next edge seq_o=000, tx_o=0, tot_o=1, state_o=4. Exit only once fault_i=0 and ptt_db=0.
6. Reset mid-KEYUP (seq_o=011): rst for one clk -> next edge all outputs 0, state_o=0. Holding ptt_i restarts the sequence from seq_o[0].
